// File: rtl/pwm_pkg.sv
// Shared constants and capture clamp for the PWM datapath (also used by the duty saturator).
package pwm_pkg;

  localparam int W = 26;
  localparam logic [W-1:0] DEF_PERIOD = W'(998);

  // Clamp v into [lo, hi]; hi carries one extra bit so "period+1" never overflows.
  function automatic logic [W-1:0] clamp_u(input logic [W-1:0] v,
                                           input logic [W-1:0] lo,
                                           input logic [W:0]   hi);
    logic [W-1:0] res;
    res = v;
    if (v < lo) begin
      res = lo;
    end else if ({1'b0, v} > hi) begin
      res = hi[W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_window_cmp.sv
// Combinational high-window decode: is cnt inside [phase, phase+duty) modulo the period?
module pwm_window_cmp
  import pwm_pkg::*;
(
  input  logic [W-1:0] i_cnt,
  input  logic [W-1:0] i_period,
  input  logic [W-1:0] i_phase,
  input  logic [W-1:0] i_duty,
  output logic         o_high
);

  logic [W:0] w_p;
  logic [W:0] w_e;
  logic [W:0] w_e_wrap;

  always_comb begin
    w_p      = {1'b0, i_period} + (W+1)'(1);
    w_e      = {1'b0, i_phase} + {1'b0, i_duty};
    w_e_wrap = w_e - w_p;
    o_high   = 1'b0;
    if (i_duty == '0) begin
      o_high = 1'b0;
    end else if ({1'b0, i_duty} >= w_p) begin
      o_high = 1'b1;
    end else if (w_e <= w_p) begin
      o_high = (i_cnt >= i_phase) && ({1'b0, i_cnt} < w_e);
    end else begin
      // Window runs past the terminal count and continues from zero.
      o_high = (i_cnt >= i_phase) || ({1'b0, i_cnt} < w_e_wrap);
    end
  end

endmodule

// File: rtl/pwm_shadow_gen.sv
// Counter PWM with double-buffered period/duty/phase committed at the period wrap.
module pwm_shadow_gen
  import pwm_pkg::*;
(
  input  logic         clk,
  input  logic         Rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] period_in,
  input  logic [W-1:0] duty_in,
  input  logic [W-1:0] phase_in,
  output logic         PWMout,
  output logic [W-1:0] cnt,
  output logic         pending,
  output logic         upd_done,
  output logic         per_start,
  output logic         per_mid
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_act_per;
  logic [W-1:0] r_act_duty;
  logic [W-1:0] r_act_phase;
  logic [W-1:0] r_sh_per;
  logic [W-1:0] r_sh_duty;
  logic [W-1:0] r_sh_phase;
  logic         r_pending;
  logic         r_upd_done_p1;
  logic         r_pwm_p1;
  logic         r_per_start_p1;
  logic         r_per_mid_p1;

  logic [W-1:0] w_cap_per;
  logic [W-1:0] w_cap_duty;
  logic [W-1:0] w_cap_phase;
  logic         w_wrap;
  logic         w_commit;
  logic         w_high;

  // Phase and duty are clamped against the newly captured period, not the active one.
  always_comb begin
    w_cap_per   = clamp_u(period_in, W'(1), {1'b0, {W{1'b1}}});
    w_cap_phase = clamp_u(phase_in, '0, {1'b0, w_cap_per});
    w_cap_duty  = clamp_u(duty_in, '0, {1'b0, w_cap_per} + (W+1)'(1));
  end

  assign w_wrap   = en && (r_cnt == r_act_per);
  assign w_commit = r_pending && (w_wrap || !en);

  pwm_window_cmp u_window (
    .i_cnt    (r_cnt),
    .i_period (r_act_per),
    .i_phase  (r_act_phase),
    .i_duty   (r_act_duty),
    .o_high   (w_high)
  );

  // Shadow and active register banks; a same-cycle load lands in the shadow after the commit reads it.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_sh_per    <= DEF_PERIOD;
      r_sh_duty   <= '0;
      r_sh_phase  <= '0;
      r_act_per   <= DEF_PERIOD;
      r_act_duty  <= '0;
      r_act_phase <= '0;
    end else begin
      if (load) begin
        r_sh_per   <= w_cap_per;
        r_sh_duty  <= w_cap_duty;
        r_sh_phase <= w_cap_phase;
      end
      if (w_commit) begin
        r_act_per   <= r_sh_per;
        r_act_duty  <= r_sh_duty;
        r_act_phase <= r_sh_phase;
      end
    end
  end

  // Stage p0 -> p1: counter advance and registered output/strobes.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_cnt          <= '0;
      r_pending      <= 1'b0;
      r_upd_done_p1  <= 1'b0;
      r_pwm_p1       <= 1'b0;
      r_per_start_p1 <= 1'b0;
      r_per_mid_p1   <= 1'b0;
    end else begin
      if (!en || w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + W'(1);
      end
      r_pending      <= load || (r_pending && !w_commit);
      r_upd_done_p1  <= w_commit;
      r_pwm_p1       <= en && w_high;
      r_per_start_p1 <= en && (r_cnt == '0);
      r_per_mid_p1   <= en && (r_cnt == (r_act_per >> 1));
    end
  end

  assign PWMout    = r_pwm_p1;
  assign cnt       = r_cnt;
  assign pending   = r_pending;
  assign upd_done  = r_upd_done_p1;
  assign per_start = r_per_start_p1;
  assign per_mid   = r_per_mid_p1;

endmodule

// File: tb/tb_pwm_shadow_gen.sv
// Directed bench for pwm_shadow_gen: shadow commit timing, window shapes, clamps, reset and enable.
module tb_pwm_shadow_gen;
  import pwm_pkg::*;

  logic         clk = 1'b0;
  logic         Rst = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] period_in = '0;
  logic [W-1:0] duty_in = '0;
  logic [W-1:0] phase_in = '0;
  logic         PWMout;
  logic [W-1:0] cnt;
  logic         pending;
  logic         upd_done;
  logic         per_start;
  logic         per_mid;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_shadow_gen dut (
    .clk       (clk),
    .Rst       (Rst),
    .en        (en),
    .load      (load),
    .period_in (period_in),
    .duty_in   (duty_in),
    .phase_in  (phase_in),
    .PWMout    (PWMout),
    .cnt       (cnt),
    .pending   (pending),
    .upd_done  (upd_done),
    .per_start (per_start),
    .per_mid   (per_mid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input logic [W-1:0] tgt, input int budget);
    int n;
    n = 0;
    while (cnt !== tgt && n < budget) begin
      tick();
      n++;
    end
    chk("wait_cnt", 32'(cnt), 32'(tgt));
  endtask

  // One 10-cycle period; pat is indexed by the counter value the output reflects.
  task automatic run_period(input logic [9:0] pat, input string tag,
                            input int la, input int da, input int lb, input int db);
    logic loaded;
    loaded = 1'b0;
    wait_cnt(W'(1), 20);
    for (int r = 0; r < 10; r++) begin
      chk({tag, "_pwm"}, 32'(PWMout), 32'(pat[r]));
      chk({tag, "_pstart"}, 32'(per_start), 32'(r == 0));
      chk({tag, "_pmid"}, 32'(per_mid), 32'(r == 4));
      if (loaded) chk({tag, "_pend"}, 32'(pending), 32'd1);
      loaded = 1'b0;
      load   = 1'b0;
      if (int'(cnt) == la) begin
        duty_in = W'(da);
        load    = 1'b1;
        loaded  = 1'b1;
      end else if (int'(cnt) == lb) begin
        duty_in = W'(db);
        load    = 1'b1;
        loaded  = 1'b1;
      end
      tick();
    end
    load = 1'b0;
  endtask

  initial begin
    #2 Rst = 1'b1;
    tick();
    tick();
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_pwm", 32'(PWMout), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_upd", 32'(upd_done), 32'd0);
    chk("rst_pstart", 32'(per_start), 32'd0);
    chk("rst_pmid", 32'(per_mid), 32'd0);
    Rst = 1'b0;

    // First load waits for the default 998 terminal count.
    en = 1'b1; load = 1'b1; period_in = W'(9); duty_in = W'(3); phase_in = '0;
    tick();
    load = 1'b0;
    chk("first_pend", 32'(pending), 32'd1);
    chk("first_cnt", 32'(cnt), 32'd1);
    chk("first_pstart", 32'(per_start), 32'd1);
    wait_cnt(W'(998), 1100);
    tick();
    chk("wrap_cnt", 32'(cnt), 32'd0);
    chk("wrap_upd", 32'(upd_done), 32'd1);
    chk("wrap_pend", 32'(pending), 32'd0);
    tick();
    chk("upd_once", 32'(upd_done), 32'd0);

    run_period(10'b0000000111, "d3a", -1, 0, -1, 0);
    run_period(10'b0000000111, "d3b", 2, 15, -1, 0);
    run_period(10'b1111111111, "dfull", 2, 0, -1, 0);
    phase_in = W'(8);
    run_period(10'b0000000000, "dzero", 2, 4, -1, 0);
    phase_in = '0;
    run_period(10'b1100000011, "ph8", 2, 3, -1, 0);
    run_period(10'b0000000111, "d3keep", 5, 6, -1, 0);
    chk("d6_pend_clr", 32'(pending), 32'd0);
    run_period(10'b0000111111, "d6", 3, 5, 9, 7);
    chk("wrapload_pend", 32'(pending), 32'd1);
    run_period(10'b0000011111, "d5", -1, 0, -1, 0);
    chk("d7_pend_clr", 32'(pending), 32'd0);
    phase_in = W'(20);
    run_period(10'b0001111111, "d7", 2, 2, -1, 0);
    phase_in  = '0;
    period_in = '0;
    run_period(10'b1000000001, "ph9", 2, 1, -1, 0);

    // Period 0 is stored as 1: two-cycle period, high while cnt==0.
    for (int i = 0; i < 6; i++) begin
      chk("p1_cnt", 32'(cnt), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("p1_pwm", 32'(PWMout), (i % 2 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    period_in = W'(9); duty_in = W'(7); phase_in = '0; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    chk("restore_upd", 32'(upd_done), 32'd1);
    chk("restore_cnt", 32'(cnt), 32'd0);
    run_period(10'b0001111111, "d7r", -1, 0, -1, 0);

    // Reset in the middle of a high window; pending shadow must be dropped.
    wait_cnt(W'(2), 20);
    duty_in = W'(2); load = 1'b1;
    tick();
    load = 1'b0;
    chk("pre_rst_pend", 32'(pending), 32'd1);
    wait_cnt(W'(4), 20);
    chk("pre_rst_pwm", 32'(PWMout), 32'd1);
    Rst = 1'b1;
    #1;
    chk("async_pwm", 32'(PWMout), 32'd0);
    chk("async_cnt", 32'(cnt), 32'd0);
    chk("async_pend", 32'(pending), 32'd0);
    tick();
    Rst = 1'b0;
    tick();
    chk("post_rst_upd", 32'(upd_done), 32'd0);
    wait_cnt(W'(500), 600);
    chk("def_pwm", 32'(PWMout), 32'd0);
    wait_cnt(W'(998), 600);
    tick();
    chk("def_wrap", 32'(cnt), 32'd0);
    chk("def_no_upd", 32'(upd_done), 32'd0);

    // Enable low: parked counter, quiet outputs, commits on every cycle.
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("off_cnt", 32'(cnt), 32'd0);
      chk("off_pwm", 32'(PWMout), 32'd0);
      chk("off_pstart", 32'(per_start), 32'd0);
      chk("off_pmid", 32'(per_mid), 32'd0);
    end
    period_in = W'(9); duty_in = W'(3); phase_in = '0; load = 1'b1;
    tick();
    load = 1'b0;
    chk("off_pend", 32'(pending), 32'd1);
    chk("off_upd0", 32'(upd_done), 32'd0);
    tick();
    chk("off_commit_pend", 32'(pending), 32'd0);
    chk("off_commit_upd", 32'(upd_done), 32'd1);
    tick();
    chk("off_upd_once", 32'(upd_done), 32'd0);
    en = 1'b1;
    tick();
    chk("on_pstart", 32'(per_start), 32'd1);
    chk("on_cnt", 32'(cnt), 32'd1);
    run_period(10'b0000000111, "en_run", -1, 0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
